// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: display codes, active-low glyph patterns (a..g = [6:0])
// and the readback FSM state type.
package seg7_pkg;

   localparam logic [4:0] CODE_BLANK = 5'd10;
   localparam logic [4:0] CODE_L     = 5'd11;
   localparam logic [4:0] CODE_O     = 5'd12;
   localparam logic [4:0] CODE_S     = 5'd13;
   localparam logic [4:0] CODE_T     = 5'd14;
   localparam logic [4:0] CODE_P     = 5'd15;
   localparam logic [4:0] CODE_A     = 5'd16;
   localparam logic [4:0] CODE_R     = 5'd17;
   localparam logic [4:0] CODE_U     = 5'd18;
   localparam logic [4:0] CODE_N     = 5'd19;
   localparam logic [4:0] CODE_C     = 5'd20;
   localparam logic [4:0] CODE_BAD   = 5'd31;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0001100;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_L     = 7'b1111001;
   localparam logic [6:0] SEG_O     = 7'b1100010;
   localparam logic [6:0] SEG_S     = 7'b0100100;
   localparam logic [6:0] SEG_T     = 7'b1110000;
   localparam logic [6:0] SEG_P     = 7'b0011000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_R     = 7'b1111010;
   localparam logic [6:0] SEG_U     = 7'b1100011;
   localparam logic [6:0] SEG_N     = 7'b1101010;
   localparam logic [6:0] SEG_C     = 7'b0110001;

   typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

   function automatic logic onehot_low(logic [3:0] an);
      return $onehot(~an);
   endfunction

   function automatic logic [1:0] digit_idx(logic [3:0] an);
      case (an)
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         4'b0111: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/seg7_to_code.sv
// Combinational reverse lookup of an active-low segment pattern to its display code.
module seg7_to_code
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [4:0] code_o,
   output logic       bad_o
);

   always_comb begin
      code_o = CODE_BAD;
      bad_o  = 1'b0;
      case (seg_i)
         SEG_0:     code_o = 5'd0;
         SEG_1:     code_o = 5'd1;
         SEG_2:     code_o = 5'd2;
         SEG_3:     code_o = 5'd3;
         SEG_4:     code_o = 5'd4;
         // SEG_S is the same pattern, so an S always reads back as 5
         SEG_5:     code_o = 5'd5;
         SEG_6:     code_o = 5'd6;
         SEG_7:     code_o = 5'd7;
         SEG_8:     code_o = 5'd8;
         SEG_9:     code_o = 5'd9;
         SEG_BLANK: code_o = CODE_BLANK;
         SEG_L:     code_o = CODE_L;
         SEG_O:     code_o = CODE_O;
         SEG_T:     code_o = CODE_T;
         SEG_P:     code_o = CODE_P;
         SEG_A:     code_o = CODE_A;
         SEG_R:     code_o = CODE_R;
         SEG_U:     code_o = CODE_U;
         SEG_N:     code_o = CODE_N;
         SEG_C:     code_o = CODE_C;
         default:   bad_o  = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_readback.sv
// Display self-test monitor: waits for each multiplexed digit to settle, decodes it back
// to a display code and publishes a coherent 4-digit frame.
module seg7_readback
   import seg7_pkg::*;
#(
   parameter int unsigned SETTLE = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] an,
   input  logic [6:0] seg,
   input  logic       clear,
   output logic [4:0] digit0,
   output logic [4:0] digit1,
   output logic [4:0] digit2,
   output logic [4:0] digit3,
   output logic       frame_valid,
   output logic       all_valid,
   output logic       bad_pattern
);

   logic [3:0]      an_q;
   logic [6:0]      seg_q;
   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [3:0]      mask_q, mask_d;
   logic [3:0][4:0] slot_q, slot_d;
   logic [3:0][4:0] digit_q;
   logic            frame_valid_q, all_valid_q, bad_q;
   logic            an_ok, match, sample, publish;
   logic [4:0]      code;
   logic            code_bad;
   logic [1:0]      idx;

   seg7_to_code u_dec (
      .seg_i  (seg_q),
      .code_o (code),
      .bad_o  (code_bad)
   );

   assign an_ok = onehot_low(an);
   assign match = an_ok && (an == an_q) && (seg == seg_q);
   assign idx   = digit_idx(an_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sample  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (an_ok) begin
               state_d = StSettle;
               cnt_d   = '0;
            end
         end
         StSettle: begin
            if (!an_ok) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (!match) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'(SETTLE - 1)) begin
                  sample  = 1'b1;
                  state_d = StHeld;
               end
            end
         end
         StHeld: begin
            if (!an_ok) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (!match) begin
               state_d = StSettle;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      slot_d = slot_q;
      mask_d = mask_q;
      if (sample) begin
         slot_d[idx] = code;
         mask_d[idx] = 1'b1;
      end
      publish = sample && (mask_d == 4'hf) && !clear;
      // clear always wins over the mask, even for the digit sampled this cycle
      if (clear || publish) begin
         mask_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_q          <= 4'hf;
         seg_q         <= 7'h7f;
         state_q       <= StIdle;
         cnt_q         <= '0;
         mask_q        <= '0;
         slot_q        <= {4{CODE_BLANK}};
         digit_q       <= {4{CODE_BLANK}};
         frame_valid_q <= 1'b0;
         all_valid_q   <= 1'b0;
         bad_q         <= 1'b0;
      end else begin
         an_q          <= an;
         seg_q         <= seg;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mask_q        <= mask_d;
         slot_q        <= slot_d;
         frame_valid_q <= publish;
         if (publish) begin
            digit_q     <= slot_d;
            all_valid_q <= 1'b1;
         end
         if (clear) begin
            bad_q <= 1'b0;
         end else if (sample && code_bad) begin
            bad_q <= 1'b1;
         end
      end
   end

   assign digit0      = digit_q[0];
   assign digit1      = digit_q[1];
   assign digit2      = digit_q[2];
   assign digit3      = digit_q[3];
   assign frame_valid = frame_valid_q;
   assign all_valid   = all_valid_q;
   assign bad_pattern = bad_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Bench for seg7_readback: directed vector table, hand-written corner sequences and
// randomized dwells checked against a dwell-level reference model.
module tb_seg7_readback;

   localparam int unsigned SETTLE = 4;

   // Reference glyph table indexed by code; first match wins, so S (13) reads as 5.
   localparam logic [6:0] PAT [21] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
      7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100, 7'b1111111, 7'b1111001,
      7'b1100010, 7'b0100100, 7'b1110000, 7'b0011000, 7'b0001000, 7'b1111010,
      7'b1100011, 7'b1101010, 7'b0110001
   };

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] an = 4'hf;
   logic [6:0] seg = 7'h7f;
   logic       clear = 1'b0;
   logic [4:0] digit0, digit1, digit2, digit3;
   logic       frame_valid, all_valid, bad_pattern;

   int n_cmp = 0;
   int n_bad = 0;

   seg7_readback #(.SETTLE(SETTLE)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .an          (an),
      .seg         (seg),
      .clear       (clear),
      .digit0      (digit0),
      .digit1      (digit1),
      .digit2      (digit2),
      .digit3      (digit3),
      .frame_valid (frame_valid),
      .all_valid   (all_valid),
      .bad_pattern (bad_pattern)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  an;
      logic [6:0]  seg;
      int          len;
      logic        clr;
      int          pulses;
      logic [19:0] digits;
      logic        all;
      logic        bad;
      logic [3:0]  mask;
   } vec_t;

   vec_t tbl [19];

   // model state
   logic [3:0][4:0] m_slot, m_digit;
   logic [3:0]      m_mask;
   logic            m_bad, m_all;

   function automatic logic [19:0] dg(int d3, int d2, int d1, int d0);
      return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
   endfunction

   function automatic logic [4:0] ref_decode(logic [6:0] s);
      for (int c = 0; c < 21; c++) begin
         if (PAT[c] == s) return 5'(c);
      end
      return 5'd31;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic run_dwell(input logic [3:0] a, input logic [6:0] s, input int len,
                            input logic clr, output int pulses);
      pulses = 0;
      for (int k = 0; k < len; k++) begin
         an    = a;
         seg   = s;
         clear = (k == 0) && clr;
         @(posedge clk);
         #1;
         if (frame_valid) pulses++;
      end
      clear = 1'b0;
   endtask

   task automatic model_reset();
      m_slot  = {4{5'd10}};
      m_digit = {4{5'd10}};
      m_mask  = '0;
      m_bad   = 1'b0;
      m_all   = 1'b0;
   endtask

   // A dwell of one-hot an lasting more than SETTLE cycles yields exactly one sample.
   task automatic model_dwell(input logic [3:0] a, input logic [6:0] s, input int len,
                              input logic clr, output int exp_p);
      int         d;
      logic [4:0] code;
      exp_p = 0;
      if (clr) begin
         m_mask = '0;
         m_bad  = 1'b0;
      end
      if ($countones(~a) == 1 && len >= int'(SETTLE) + 1) begin
         d = 0;
         for (int i = 0; i < 4; i++) if (!a[i]) d = i;
         code      = ref_decode(s);
         m_slot[d] = code;
         m_mask[d] = 1'b1;
         if (code == 5'd31) m_bad = 1'b1;
         if (m_mask == 4'hf) begin
            m_digit = m_slot;
            m_all   = 1'b1;
            m_mask  = '0;
            exp_p   = 1;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      an    = 4'hf;
      seg   = 7'h7f;
      clear = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int         p, ep;
      logic [3:0] a, pa;
      logic [6:0] s, ps;
      int         len;
      logic       clr;

      tbl[0]  = '{4'b1110, 7'b0000001, 3,  1'b0, 0, dg(10, 10, 10, 10), 1'b0, 1'b0, 4'b0000};
      tbl[1]  = '{4'b1110, 7'b1001111, 6,  1'b0, 0, dg(10, 10, 10, 10), 1'b0, 1'b0, 4'b0001};
      tbl[2]  = '{4'b1101, 7'b0010010, 6,  1'b0, 0, dg(10, 10, 10, 10), 1'b0, 1'b0, 4'b0011};
      tbl[3]  = '{4'b1011, 7'b0000110, 6,  1'b0, 0, dg(10, 10, 10, 10), 1'b0, 1'b0, 4'b0111};
      tbl[4]  = '{4'b0111, 7'b0001100, 6,  1'b0, 1, dg(9, 3, 2, 1),     1'b1, 1'b0, 4'b0000};
      tbl[5]  = '{4'b1110, 7'b0100100, 6,  1'b0, 0, dg(9, 3, 2, 1),     1'b1, 1'b0, 4'b0001};
      tbl[6]  = '{4'b1101, 7'b1110000, 6,  1'b0, 0, dg(9, 3, 2, 1),     1'b1, 1'b0, 4'b0011};
      tbl[7]  = '{4'b1011, 7'b1100010, 6,  1'b0, 0, dg(9, 3, 2, 1),     1'b1, 1'b0, 4'b0111};
      tbl[8]  = '{4'b0111, 7'b0011000, 6,  1'b0, 1, dg(15, 12, 14, 5),  1'b1, 1'b0, 4'b0000};
      tbl[9]  = '{4'b1110, 7'b0000000, 6,  1'b0, 0, dg(15, 12, 14, 5),  1'b1, 1'b0, 4'b0001};
      tbl[10] = '{4'b1101, 7'b0000000, 6,  1'b0, 0, dg(15, 12, 14, 5),  1'b1, 1'b0, 4'b0011};
      tbl[11] = '{4'b1011, 7'b1010101, 6,  1'b0, 0, dg(15, 12, 14, 5),  1'b1, 1'b1, 4'b0111};
      tbl[12] = '{4'b0111, 7'b0000000, 6,  1'b0, 1, dg(8, 31, 8, 8),    1'b1, 1'b1, 4'b0000};
      tbl[13] = '{4'b1111, 7'b1111111, 3,  1'b1, 0, dg(8, 31, 8, 8),    1'b1, 1'b0, 4'b0000};
      tbl[14] = '{4'b1100, 7'b0000001, 20, 1'b0, 0, dg(8, 31, 8, 8),    1'b1, 1'b0, 4'b0000};
      tbl[15] = '{4'b1110, 7'b1001111, 50, 1'b0, 0, dg(8, 31, 8, 8),    1'b1, 1'b0, 4'b0001};
      tbl[16] = '{4'b1101, 7'b1001111, 6,  1'b0, 0, dg(8, 31, 8, 8),    1'b1, 1'b0, 4'b0011};
      tbl[17] = '{4'b1011, 7'b1001111, 6,  1'b0, 0, dg(8, 31, 8, 8),    1'b1, 1'b0, 4'b0111};
      tbl[18] = '{4'b0111, 7'b0100000, 50, 1'b0, 1, dg(6, 1, 1, 1),     1'b1, 1'b0, 4'b0000};

      @(posedge clk);
      do_reset();
      check("reset digits", {digit3, digit2, digit1, digit0}, dg(10, 10, 10, 10));
      check("reset frame_valid", frame_valid, 0);
      check("reset all_valid", all_valid, 0);
      check("reset bad_pattern", bad_pattern, 0);
      check("reset mask", dut.mask_q, 0);

      for (int i = 0; i < 19; i++) begin
         run_dwell(tbl[i].an, tbl[i].seg, tbl[i].len, tbl[i].clr, p);
         check($sformatf("vec%0d pulses", i), p, tbl[i].pulses);
         check($sformatf("vec%0d digits", i), {digit3, digit2, digit1, digit0}, tbl[i].digits);
         check($sformatf("vec%0d all_valid", i), all_valid, tbl[i].all);
         check($sformatf("vec%0d bad_pattern", i), bad_pattern, tbl[i].bad);
         check($sformatf("vec%0d mask", i), dut.mask_q, tbl[i].mask);
      end

      // clear on the very edge that would complete a frame with a bad digit
      run_dwell(4'b1110, 7'b0010010, 6, 1'b0, p);
      run_dwell(4'b1101, 7'b0010010, 6, 1'b0, p);
      run_dwell(4'b1011, 7'b0010010, 6, 1'b0, p);
      run_dwell(4'b0111, 7'b1010101, SETTLE, 1'b0, p);
      check("pre-clear mask", dut.mask_q, 4'b0111);
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check("clr+sample frame_valid", frame_valid, 0);
      check("clr+sample bad_pattern", bad_pattern, 0);
      check("clr+sample mask", dut.mask_q, 0);
      check("clr+sample slot3", dut.slot_q[3], 31);
      check("clr+sample digits", {digit3, digit2, digit1, digit0}, dg(6, 1, 1, 1));
      @(posedge clk);
      #1;
      check("held no resample", dut.mask_q, 0);

      // reset with a partial frame, then a fresh frame with a one-cycle pulse
      run_dwell(4'b1110, 7'b0000110, 6, 1'b0, p);
      run_dwell(4'b1101, 7'b0000110, 6, 1'b0, p);
      run_dwell(4'b1011, 7'b0000110, 6, 1'b0, p);
      do_reset();
      check("midframe rst digits", {digit3, digit2, digit1, digit0}, dg(10, 10, 10, 10));
      check("midframe rst all_valid", all_valid, 0);
      check("midframe rst mask", dut.mask_q, 0);
      run_dwell(4'b1110, 7'b0001000, 6, 1'b0, p);
      run_dwell(4'b1101, 7'b1111010, 6, 1'b0, p);
      run_dwell(4'b1011, 7'b1100011, 6, 1'b0, p);
      run_dwell(4'b0111, 7'b0110001, SETTLE + 1, 1'b0, p);
      check("fresh frame pulse", frame_valid, 1);
      check("fresh frame digits", {digit3, digit2, digit1, digit0}, dg(20, 18, 17, 16));
      check("fresh frame all_valid", all_valid, 1);
      @(posedge clk);
      #1;
      check("pulse one cycle", frame_valid, 0);

      // randomized dwells against the model
      do_reset();
      model_reset();
      pa = 4'hf;
      ps = 7'h7f;
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) != 0) a = ~(4'b0001 << $urandom_range(0, 3));
         else a = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 4) != 0) s = PAT[$urandom_range(0, 20)];
         else s = 7'($urandom_range(0, 127));
         if (a == pa && s == ps) s = s ^ 7'h01;
         len = $urandom_range(1, SETTLE + 4);
         clr = ($urandom_range(0, 9) == 0);
         model_dwell(a, s, len, clr, ep);
         run_dwell(a, s, len, clr, p);
         check($sformatf("rnd%0d pulses", n), p, ep);
         check($sformatf("rnd%0d digits", n), {digit3, digit2, digit1, digit0}, m_digit);
         check($sformatf("rnd%0d all_valid", n), all_valid, m_all);
         check($sformatf("rnd%0d bad_pattern", n), bad_pattern, m_bad);
         check($sformatf("rnd%0d mask", n), dut.mask_q, m_mask);
         pa = a;
         ps = s;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_readback.md
# seg7_readback

Self-test monitor for the wristwatch's multiplexed 7-segment display. It watches the active-low anode and segment lines driven to the 4-digit display and waits for each digit's pattern to be stable. It then decodes the pattern back to the 5-bit display code (digits 0-9, blank, glyphs l o S t p A r u n C) and publishes a coherent 4-digit frame. It sits beside the display driver and feeds the BIST/compare logic.

## Interface
- `SETTLE`, default 4: consecutive stable cycles required before a digit is sampled; legal range 1..15.

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, synchronous, active-low
- `an`  in  4  digit enables, active-low; exactly one low bit = valid digit select (`an[0]` = digit 0)
- `seg`  in  7  segment lines, active-low; `seg[6]`=a … `seg[0]`=g
- `clear`  in  1  synchronous clear of the capture mask and `bad_pattern`
- `digit0`..`digit3`  out  5 each  decoded code of last complete frame
- `frame_valid`  out  1  one-cycle pulse when the digit outputs update
- `all_valid`  out  1  high once any frame has been published since reset
- `bad_pattern`  out  1  sticky; a sampled pattern matched no code

## Operation
- Input stage: `an_r`/`seg_r` register `an`/`seg` every cycle; all decisions use the registered copies.
- Input match: the current `an`/`seg` equal `an_r`/`seg_r` and `an` is one-hot-low.
- FSM states:
  - **IDLE**: `an` not one-hot-low. `cnt`=0.
  - **SETTLE**: `cnt` counts up.
  - **HELD**: digit already sampled, waiting for an input change.
- IDLE→SETTLE: on the first cycle with one-hot `an`; `cnt`=0.
- SETTLE:
  - Input match → `cnt`+1.
  - Any change → `cnt`=0, stay in SETTLE.
  - Non-one-hot `an` → IDLE.
  - Reaching `cnt`==SETTLE → sample → HELD.
- HELD: any change of `an`/`seg` → SETTLE (`cnt`=0), or IDLE if `an` is not one-hot. Exactly one sample per dwell.
- Sample:
  - Decode `seg_r` and write the code into working slot `idx(an_r)`; set `mask[idx]`.
  - A re-sample of an already-captured digit overwrites the slot; `mask` is unchanged.
- Decode:
  - Patterns for codes 0-12 and 14-20 map to those codes.
  - 7'b0100100 decodes as 5, never 13; S and 5 are indistinguishable.
  - 7'b1111111 decodes as 10 (blank).
  - Any other pattern decodes as 31 and sets `bad_pattern`.
- Frame publish: when a sample makes `mask`==4'b1111:
  - Working slots (including the just-decoded value) copy to `digit0..3`.
  - `frame_valid` pulses.
  - `all_valid` sets.
  - `mask` clears.
- `clear`:
  - Clears `mask` and `bad_pattern`; does not alter `digit0..3`, `all_valid` or the FSM.
  - If asserted in the same cycle as a sample, the sample still writes its slot. Its `mask` bit is cleared, so `clear` wins for the mask.
  - A publish is suppressed.
  - `bad_pattern` is cleared, even if that cycle's sample decoded to 31.

## Timing
- Reset values:
  - `digit0..3` = 10
  - `frame_valid`, `all_valid`, `bad_pattern` = 0
  - `mask` = 0, `cnt` = 0, FSM = IDLE
  - `an_r` = 4'b1111, `seg_r` = 7'b1111111
- Latency:
  - Inputs first present at edge T (captured into `an_r`/`seg_r`).
  - Sample write at edge T+SETTLE.
  - `bad_pattern` visible after edge T+SETTLE.
- Frame: `digit0..3` and `frame_valid` become valid after the sampling edge of the last missing digit. `frame_valid` is high for exactly that one cycle.
- A change at or before edge T+SETTLE-1 restarts the count; no partial sample.
- Reset mid-dwell or mid-frame: all state returns to reset values on that edge; a partial frame is discarded.
- Inputs are synchronous to `clk`; no metastability hardening.

## Structure
- Package `seg7_pkg`:
  - Code constants CODE_BLANK=10, CODE_L=11 … CODE_C=20, CODE_BAD=31.
  - Segment pattern constants for each code.
  - FSM state enum.
  - Shared with the forward code-to-segment decoder.
- Sub-module `seg7_to_code`: pure combinational pattern→{code, bad} lookup, instantiated once on `seg_r`.

## Test plan
- Reset, SETTLE=4 → digits all 10, pulses low. Then hold `an`=4'b1110 with `seg`=7'b0000001 (0) for 3 cycles and change → no sample, `mask`=0.
- Cycle digits 0..3 with patterns for 1, 2, 3 (7'b0000110) and 9 (7'b0001100), each for 6 cycles → one `frame_valid` pulse; `digit0..3`=1,2,3,9; `all_valid`=1.
- Display "StoP" (0100100, 1110000, 1100010, 0011000) → digits 5,14,12,15 (S reads as 5).
- Drive pattern 7'b1010101 on digit 2 → digit2=31 at publish, `bad_pattern`=1 and sticky. Then `clear` → `bad_pattern`=0, digits unchanged.
- Drive `an`=4'b1100 (two digits) for 20 cycles → FSM stays IDLE, no sample. Hold a valid digit 50 cycles → exactly one sample.
- After 3 digits are captured, pulse `rst_n` low for one cycle → no publish, `mask`=0, digits = 10. A fresh full frame publishes normally.
